// File: rtl/dfa_ctx_sched.sv
// dfa_ctx_sched: round-robin time-multiplexer of one combinational DFA engine across NCH symbol streams
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_sym        per-channel symbol offers; req_ready one-hot grant
//   ch_clear                 per-channel context restart (beats a same-channel grant)
//   dfa_state_o/dfa_sym_o    granted channel context and symbol to the engine (0 when idle)
//   dfa_next_i/dfa_accept_i  engine result, written back at the next posedge
//   match_valid/match_ch     registered pulse and channel of an accepting transition
//   match_count              saturating count of accepting transitions
module dfa_ctx_sched #(
  parameter int NCH = 4,
  parameter int SW = 2,
  parameter int STW = 3,
  parameter logic [STW-1:0] START_STATE = '0,
  parameter int CW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req_valid,
  input  logic [NCH*SW-1:0]        req_sym,
  output logic [NCH-1:0]           req_ready,
  input  logic [NCH-1:0]           ch_clear,
  output logic [STW-1:0]           dfa_state_o,
  output logic [SW-1:0]            dfa_sym_o,
  input  logic [STW-1:0]           dfa_next_i,
  input  logic                     dfa_accept_i,
  output logic                     match_valid,
  output logic [$clog2(NCH)-1:0]   match_ch,
  output logic [CW-1:0]            match_count
);
  localparam int PW = $clog2(NCH);
  logic [STW-1:0] ctx_q [NCH];
  logic [STW-1:0] ctx_d [NCH];
  logic [PW-1:0]  rr_q, rr_d, mc_q, mc_d, gidx;
  logic           mv_q, mv_d, gv;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] elig;
  int             idx;
  assign elig = req_valid & ~ch_clear & {NCH{~rst}};
  // Scan downward so the last hit is the nearest eligible channel at or after rr_q.
  always_comb begin
    gv = 1'b0;
    gidx = '0;
    idx = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NCH;
      if (elig[PW'(idx)]) begin
        gv = 1'b1;
        gidx = PW'(idx);
      end
    end
  end
  always_comb begin
    req_ready = gv ? NCH'(1) << gidx : '0;
    dfa_state_o = gv ? ctx_q[gidx] : '0;
    dfa_sym_o = gv ? req_sym[gidx*SW +: SW] : '0;
    match_valid = mv_q;
    match_ch = mc_q;
    match_count = cnt_q;
  end
  // Clears are applied after the write-back; a cleared channel is never granted anyway.
  always_comb begin
    ctx_d = ctx_q;
    if (gv) ctx_d[gidx] = dfa_next_i;
    for (int i = 0; i < NCH; i++) if (ch_clear[i]) ctx_d[i] = START_STATE;
    rr_d = gv ? PW'((int'(gidx) + 1) % NCH) : rr_q;
    mv_d = gv & dfa_accept_i;
    mc_d = gv ? gidx : mc_q;
    cnt_d = (mv_d && cnt_q != {CW{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_q <= '{default: START_STATE};
      rr_q <= '0;
      mv_q <= 1'b0;
      mc_q <= '0;
      cnt_q <= '0;
    end else begin
      ctx_q <= ctx_d;
      rr_q <= rr_d;
      mv_q <= mv_d;
      mc_q <= mc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_dfa_ctx_sched.sv
// tb_dfa_ctx_sched: directed bench with a "101" detector engine and a behavioural scheduler model
module tb_dfa_ctx_sched;
  localparam int NCH = 4, SW = 2, STW = 3;
  logic clk, rst;
  logic [NCH-1:0] req_valid, ch_clear, rdy_a, rdy_b;
  logic [NCH*SW-1:0] req_sym;
  logic [STW-1:0] st_a, st_b, nx_a, nx_b;
  logic [SW-1:0] sy_a, sy_b;
  logic acc_a, acc_b, mv_a, mv_b;
  logic [1:0] mc_a, mc_b;
  logic [15:0] cnt_a;
  logic [2:0] cnt_b;
  int n_cmp = 0, n_bad = 0;
  int m_ctx [NCH];
  int m_rr = 0, m_mv = 0, m_mc = 0, m_cnt = 0;

  // External engine: overlapping "101" detector on symbol bit 0; state 3 accepts.
  function automatic logic [3:0] eng(logic [2:0] s, logic [1:0] y);
    logic [2:0] n;
    n = y[0] ? (s == 3'd2 ? 3'd3 : 3'd1) : ((s == 3'd1 || s == 3'd3) ? 3'd2 : 3'd0);
    return {n == 3'd3, n};
  endfunction

  assign {acc_a, nx_a} = eng(st_a, sy_a);
  assign {acc_b, nx_b} = eng(st_b, sy_b);

  dfa_ctx_sched #(.NCH(NCH), .SW(SW), .STW(STW), .CW(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sym(req_sym), .req_ready(rdy_a),
    .ch_clear(ch_clear), .dfa_state_o(st_a), .dfa_sym_o(sy_a), .dfa_next_i(nx_a),
    .dfa_accept_i(acc_a), .match_valid(mv_a), .match_ch(mc_a), .match_count(cnt_a));

  dfa_ctx_sched #(.NCH(NCH), .SW(SW), .STW(STW), .CW(3)) u_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sym(req_sym), .req_ready(rdy_b),
    .ch_clear(ch_clear), .dfa_state_o(st_b), .dfa_sym_o(sy_b), .dfa_next_i(nx_b),
    .dfa_accept_i(acc_b), .match_valid(mv_b), .match_ch(mc_b), .match_count(cnt_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: at each negedge check outputs against the state after the last posedge,
  // then advance the model with the inputs the next posedge will sample.
  always @(negedge clk) begin
    int g, i, s, ex_ready, ex_st, ex_sy;
    logic [3:0] r;
    g = -1;
    if (!rst)
      for (int k = 0; k < NCH; k++) begin
        i = (m_rr + k) % NCH;
        if (g < 0 && req_valid[i] && !ch_clear[i]) g = i;
      end
    ex_ready = g < 0 ? 0 : 1 << g;
    ex_st = g < 0 ? 0 : m_ctx[g];
    ex_sy = g < 0 ? 0 : int'(req_sym[g*SW +: SW]);
    chk("req_ready", int'(rdy_a), ex_ready);
    chk("dfa_state_o", int'(st_a), ex_st);
    chk("dfa_sym_o", int'(sy_a), ex_sy);
    chk("match_valid", int'(mv_a), m_mv);
    chk("match_ch", int'(mc_a), m_mc);
    chk("match_count", int'(cnt_a), m_cnt > 65535 ? 65535 : m_cnt);
    chk("sat_req_ready", int'(rdy_b), ex_ready);
    chk("sat_match_count", int'(cnt_b), m_cnt > 7 ? 7 : m_cnt);
    if (rst) begin
      for (int k = 0; k < NCH; k++) m_ctx[k] = 0;
      m_rr = 0; m_mv = 0; m_mc = 0; m_cnt = 0;
    end else begin
      m_mv = 0;
      if (g >= 0) begin
        s = int'(req_sym[g*SW +: SW]);
        r = eng(3'(m_ctx[g]), 2'(s));
        m_ctx[g] = int'(r[2:0]);
        m_mv = int'(r[3]);
        m_mc = g;
        m_rr = (g + 1) % NCH;
      end
      m_cnt += m_mv;
      for (int k = 0; k < NCH; k++) if (ch_clear[k]) m_ctx[k] = 0;
    end
  end

  task automatic put(logic [NCH-1:0] v, logic [NCH-1:0] c, logic [NCH*SW-1:0] s);
    req_valid = v;
    ch_clear = c;
    req_sym = s;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Symbol for one channel, others 0.
  function automatic logic [NCH*SW-1:0] sym1(int ch, logic [SW-1:0] v);
    return (NCH*SW)'(v) << (ch * SW);
  endfunction

  initial begin
    for (int k = 0; k < NCH; k++) m_ctx[k] = 0;
    rst = 1'b1;
    req_valid = '0; ch_clear = '0; req_sym = '0;
    for (int k = 0; k < 2; k++) begin
      put('1, '0, '0);
      chk("rst_ready", int'(rdy_a), 0);
      tick();
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      put('1, '0, '0);
      chk("rr_grant", int'(rdy_a), 1 << (k % 4));
      if (k == 0) begin
        chk("post_rst_mv", int'(mv_a), 0);
        chk("post_rst_cnt", int'(cnt_a), 0);
      end
      tick();
    end
    put(4'b0001, '0, sym1(0, 1)); tick();
    put(4'b0100, '0, sym1(2, 1)); tick();
    put(4'b0001, '0, sym1(0, 0)); tick();
    put(4'b0100, '0, sym1(2, 1)); tick();
    put(4'b0001, '0, sym1(0, 1));
    chk("iso_no_early", int'(mv_a), 0);
    tick();
    put(4'b0100, '0, sym1(2, 0));
    chk("iso_mv", int'(mv_a), 1);
    chk("iso_ch", int'(mc_a), 0);
    tick();
    put(4'b0100, '0, sym1(2, 0));
    chk("iso_mv_off", int'(mv_a), 0);
    chk("iso_ch2_ctx", int'(st_a), 2);
    chk("iso_cnt", int'(cnt_a), 1);
    tick();
    put(4'b0010, '0, sym1(1, 1)); tick();
    put(4'b0001, '0, '0); tick();
    put(4'b1010, 4'b0010, sym1(1, 1));
    chk("clr_grant", int'(rdy_a), 8);
    tick();
    put(4'b0010, '0, sym1(1, 0));
    chk("clr_ctx1", int'(st_a), 0);
    chk("clr_grant1", int'(rdy_a), 2);
    tick();
    for (int k = 0; k < 5; k++) begin
      put('0, '0, '1);
      chk("idle_ready", int'(rdy_a), 0);
      chk("idle_state", int'(st_a), 0);
      chk("idle_sym", int'(sy_a), 0);
      if (k > 0) chk("idle_mv", int'(mv_a), 0);
      tick();
    end
    put('1, '0, '0);
    chk("idle_rr_hold", int'(rdy_a), 4);
    tick();
    put(4'b1000, '0, sym1(3, 1)); tick();
    put(4'b1000, '0, sym1(3, 0)); tick();
    for (int k = 0; k < 9; k++) begin
      put(4'b1000, '0, sym1(3, 1)); tick();
      put(4'b1000, '0, sym1(3, 0)); tick();
    end
    put('0, '0, '0);
    chk("sat_cnt3", int'(cnt_b), 7);
    chk("cnt16", int'(cnt_a), 10);
    tick();
    put(4'b1000, '0, sym1(3, 1)); tick();
    rst = 1'b1;
    put('1, '0, '0);
    chk("mid_rst_mv", int'(mv_a), 1);
    tick();
    rst = 1'b0;
    put('1, '0, '0);
    chk("mid_rst_drop", int'(mv_a), 0);
    chk("mid_rst_grant", int'(rdy_a), 1);
    tick();
    put('0, '0, '0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
